// File: rtl/seg14_pkg.sv
// seg14_pkg: shared types and constants for the 14-segment scroll driver.
// Character codes, segment pattern type and the blank pattern.
package seg14_pkg;

   typedef logic [13:0] seg14_t;
   typedef logic [5:0]  char_t;

   localparam seg14_t SEG_BLANK = 14'b0;

   localparam char_t CH_SPACE = 6'd0;
   localparam char_t CH_A     = 6'd1;
   localparam char_t CH_B     = 6'd2;
   localparam char_t CH_C     = 6'd3;
   localparam char_t CH_D     = 6'd4;
   localparam char_t CH_E     = 6'd5;
   localparam char_t CH_F     = 6'd6;
   localparam char_t CH_G     = 6'd7;
   localparam char_t CH_H     = 6'd8;
   localparam char_t CH_I     = 6'd9;
   localparam char_t CH_J     = 6'd10;
   localparam char_t CH_K     = 6'd11;
   localparam char_t CH_L     = 6'd12;
   localparam char_t CH_M     = 6'd13;
   localparam char_t CH_N     = 6'd14;
   localparam char_t CH_O     = 6'd15;
   localparam char_t CH_P     = 6'd16;
   localparam char_t CH_Q     = 6'd17;
   localparam char_t CH_R     = 6'd18;
   localparam char_t CH_S     = 6'd19;
   localparam char_t CH_T     = 6'd20;
   localparam char_t CH_U     = 6'd21;
   localparam char_t CH_V     = 6'd22;
   localparam char_t CH_W     = 6'd23;
   localparam char_t CH_X     = 6'd24;
   localparam char_t CH_Y     = 6'd25;
   localparam char_t CH_Z     = 6'd26;
   localparam char_t CH_0     = 6'd27;
   localparam char_t CH_1     = 6'd28;
   localparam char_t CH_2     = 6'd29;
   localparam char_t CH_3     = 6'd30;
   localparam char_t CH_4     = 6'd31;
   localparam char_t CH_5     = 6'd32;
   localparam char_t CH_6     = 6'd33;
   localparam char_t CH_7     = 6'd34;
   localparam char_t CH_8     = 6'd35;
   localparam char_t CH_9     = 6'd36;

endpackage

// File: rtl/seg14_scroll_driver_font.sv
// seg14_font: combinational character code to 14-segment pattern lookup.
// Bit order a,b,c,d,e,f,g1,g2,h,i,j,k,l,m from bit 13 down; unknown codes blank.
module seg14_font
   import seg14_pkg::*;
(
   input  logic [5:0] code_i,
   output seg14_t     seg_o
);

   // Font ROM; codes beyond the digits render blank.
   always_comb begin
      seg_o = SEG_BLANK;
      case (code_i)
         CH_SPACE: seg_o = SEG_BLANK;
         CH_A:     seg_o = 14'b11101111000000;
         CH_B:     seg_o = 14'b11110001010010;
         CH_C:     seg_o = 14'b10011100000000;
         CH_D:     seg_o = 14'b11110000010010;
         CH_E:     seg_o = 14'b10011110000000;
         CH_F:     seg_o = 14'b10001110000000;
         CH_G:     seg_o = 14'b10111101000000;
         CH_H:     seg_o = 14'b01101111000000;
         CH_I:     seg_o = 14'b10010000010010;
         CH_J:     seg_o = 14'b01111000000000;
         CH_K:     seg_o = 14'b00001110001100;
         CH_L:     seg_o = 14'b00011100000000;
         CH_M:     seg_o = 14'b01101100101000;
         CH_N:     seg_o = 14'b01101100100100;
         CH_O:     seg_o = 14'b11111100000000;
         CH_P:     seg_o = 14'b11001111000000;
         CH_Q:     seg_o = 14'b11111100000100;
         CH_R:     seg_o = 14'b11001111000100;
         CH_S:     seg_o = 14'b10110111000000;
         CH_T:     seg_o = 14'b10000000010010;
         CH_U:     seg_o = 14'b01111100000000;
         CH_V:     seg_o = 14'b00001100001001;
         CH_W:     seg_o = 14'b01101100000101;
         CH_X:     seg_o = 14'b00000000101101;
         CH_Y:     seg_o = 14'b00000000101010;
         CH_Z:     seg_o = 14'b10010000001001;
         CH_0:     seg_o = 14'b11111100001001;
         CH_1:     seg_o = 14'b01100000001000;
         CH_2:     seg_o = 14'b11011011000000;
         CH_3:     seg_o = 14'b11110001000000;
         CH_4:     seg_o = 14'b01100111000000;
         CH_5:     seg_o = 14'b10110111000000;
         CH_6:     seg_o = 14'b10111111000000;
         CH_7:     seg_o = 14'b11100000000000;
         CH_8:     seg_o = 14'b11111111000000;
         CH_9:     seg_o = 14'b11110111000000;
         default:  seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg14_scroll_driver.sv
// seg14_scroll_driver: multiplexed 14-segment scanner with message buffer and scroll.
// Define SEG14_BLANK_EN for a one-clock sel/segm blanking gap at each slot start.
module seg14_scroll_driver
   import seg14_pkg::*;
#(
   parameter int unsigned DIGITS        = 12,
   parameter int unsigned MSG_LEN       = 16,
   parameter int unsigned PRESCALE      = 4,
   parameter int unsigned SCROLL_FRAMES = 8
)
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
   input  logic [5:0]                 wr_char,
   input  logic                       scroll_en,
   output logic [DIGITS-1:0]          sel,
   output logic [13:0]                segm,
   output logic                       frame_tick
);

   localparam int unsigned AW  = $clog2(MSG_LEN);
   localparam int unsigned AW1 = AW + 1;
   localparam int unsigned PW  = $clog2(PRESCALE);
   localparam int unsigned DW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned FW  = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

   localparam logic [PW-1:0]     PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [DW-1:0]     DIG_LAST = DW'(DIGITS - 1);
   localparam logic [FW-1:0]     FRM_LAST = FW'(SCROLL_FRAMES - 1);
   localparam logic [AW-1:0]     OFF_LAST = AW'(MSG_LEN - 1);
   localparam logic [AW:0]       LEN_W    = AW1'(MSG_LEN);
   localparam logic [DIGITS-1:0] SEL_ONE  = DIGITS'(1);

   logic [PW-1:0]     pre_q, pre_d;
   logic [DW-1:0]     dig_q, dig_d;
   logic [FW-1:0]     frm_q, frm_d;
   logic [AW-1:0]     off_q, off_d;
   logic [5:0]        buf_q [MSG_LEN];
   logic [DIGITS-1:0] sel_q, sel_d;
   seg14_t            segm_q, segm_d;
   logic              tick_q, tick_d;

   logic              slot_tick;
   logic              frame_wrap;
   logic [AW:0]       sum_w;
   logic [AW-1:0]     rd_idx;
   logic [5:0]        cur_char;
   seg14_t            cur_seg;

   assign slot_tick  = (pre_q == PRE_LAST);
   assign frame_wrap = slot_tick && (dig_q == DIG_LAST);

   // Buffer position shown on the current digit: (offset + digit) mod MSG_LEN.
   assign sum_w    = {1'b0, off_q} + AW1'(dig_q);
   assign rd_idx   = (sum_w >= LEN_W) ? AW'(sum_w - LEN_W) : sum_w[AW-1:0];
   assign cur_char = buf_q[rd_idx];

   seg14_font u_font (
      .code_i (cur_char),
      .seg_o  (cur_seg)
   );

   // Prescaler, digit scan, frame counter and scroll offset next state.
   always_comb begin
      pre_d  = slot_tick ? '0 : pre_q + 1'b1;
      dig_d  = dig_q;
      frm_d  = frm_q;
      off_d  = off_q;
      tick_d = frame_wrap;
      if (slot_tick) begin
         dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
      end
      if (frame_wrap && scroll_en) begin
         if (frm_q == FRM_LAST) begin
            frm_d = '0;
            off_d = (off_q == OFF_LAST) ? '0 : off_q + 1'b1;
         end else begin
            frm_d = frm_q + 1'b1;
         end
      end
   end

   // Output registers load once per slot so mid-slot writes never disturb them.
   always_comb begin
      sel_d  = sel_q;
      segm_d = segm_q;
`ifdef SEG14_BLANK_EN
      if (pre_q == '0) begin
         sel_d  = '0;
         segm_d = SEG_BLANK;
      end else if (pre_q == PW'(1)) begin
         sel_d  = SEL_ONE << dig_q;
         segm_d = cur_seg;
      end
`else
      if (pre_q == '0) begin
         sel_d  = SEL_ONE << dig_q;
         segm_d = cur_seg;
      end
`endif
   end

   // Timing, scroll and output state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q  <= '0;
         dig_q  <= '0;
         frm_q  <= '0;
         off_q  <= '0;
         sel_q  <= '0;
         segm_q <= SEG_BLANK;
         tick_q <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         dig_q  <= dig_d;
         frm_q  <= frm_d;
         off_q  <= off_d;
         sel_q  <= sel_d;
         segm_q <= segm_d;
         tick_q <= tick_d;
      end
   end

   // Message buffer; writes past the end of the buffer are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(MSG_LEN); i++) begin
            buf_q[i] <= CH_SPACE;
         end
      end else if (wr_en && ({1'b0, wr_addr} < LEN_W)) begin
         buf_q[wr_addr] <= wr_char;
      end
   end

   assign sel        = sel_q;
   assign segm       = segm_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg14_scroll_driver.sv
// tb_seg14_scroll_driver: directed scoreboard bench for seg14_scroll_driver.
// Honours SEG14_BLANK_EN to expect the slot-start blanking gap.
module tb_seg14_scroll_driver;

   localparam int DIGITS        = 12;
   localparam int MSG_LEN       = 13;
   localparam int PRESCALE      = 4;
   localparam int SCROLL_FRAMES = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [5:0]  wr_char = '0;
   logic        scroll_en = 1'b0;
   logic [11:0] sel;
   logic [13:0] segm;
   logic        frame_tick;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [11:0] sel;
      logic [13:0] segm;
   } exp_t;

   typedef struct packed {
      logic [3:0] a;
      logic [5:0] c;
   } wr_t;

   exp_t       sb[$];
   wr_t        wq[$];
   logic [5:0] mbuf [MSG_LEN];
   int         off_m = 0;
   int         frm_m = 0;

   always #5 clk = ~clk;

   seg14_scroll_driver #(
      .DIGITS        (DIGITS),
      .MSG_LEN       (MSG_LEN),
      .PRESCALE      (PRESCALE),
      .SCROLL_FRAMES (SCROLL_FRAMES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_char    (wr_char),
      .scroll_en  (scroll_en),
      .sel        (sel),
      .segm       (segm),
      .frame_tick (frame_tick)
   );

   function automatic logic [13:0] font_m(input logic [5:0] c);
      case (c)
         6'd1:    return 14'b11101111000000;
         6'd5:    return 14'b10011110000000;
         6'd9:    return 14'b10010000010010;
         6'd12:   return 14'b00011100000000;
         6'd15:   return 14'b11111100000000;
         6'd18:   return 14'b11001111000100;
         6'd19:   return 14'b10110111000000;
         default: return 14'b0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame();
      logic [11:0] one;
      exp_t e;
      one = 12'd1;
      for (int d = 0; d < DIGITS; d++) begin
         e.sel  = one << d;
         e.segm = font_m(mbuf[(off_m + d) % MSG_LEN]);
         sb.push_back(e);
      end
   endtask

   task automatic model_wrap();
      if (scroll_en) begin
         frm_m++;
         if (frm_m == SCROLL_FRAMES) begin
            frm_m = 0;
            off_m = (off_m + 1) % MSG_LEN;
         end
      end
   endtask

   // Entered at the negedge of slot 0, first clock; leaves at the next one.
   task automatic run_frame(input string tag, input bit do_wr,
                            input logic [3:0] wa, input logic [5:0] wc);
      exp_t e;
      push_frame();
      if (do_wr) begin
         wr_en   = 1'b1;
         wr_addr = wa;
         wr_char = wc;
         if (int'(wa) < MSG_LEN) mbuf[wa] = wc;
      end
      for (int d = 0; d < DIGITS; d++) begin
         if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            e = '0;
         end else begin
            e = sb.pop_front();
         end
         for (int c = 0; c < PRESCALE; c++) begin
`ifdef SEG14_BLANK_EN
            if (c == 0) begin
               chk($sformatf("%s_d%0d_blank_sel", tag, d), 32'(sel), 32'd0);
               chk($sformatf("%s_d%0d_blank_segm", tag, d), 32'(segm), 32'd0);
            end else begin
               chk($sformatf("%s_d%0d_sel", tag, d), 32'(sel), 32'(e.sel));
               chk($sformatf("%s_d%0d_segm", tag, d), 32'(segm), 32'(e.segm));
            end
`else
            chk($sformatf("%s_d%0d_sel", tag, d), 32'(sel), 32'(e.sel));
            chk($sformatf("%s_d%0d_segm", tag, d), 32'(segm), 32'(e.segm));
`endif
            chk($sformatf("%s_d%0d_tick", tag, d), 32'(frame_tick),
                32'((d == DIGITS - 1) && (c == PRESCALE - 1)));
            @(negedge clk);
            wr_en = 1'b0;
         end
      end
      model_wrap();
   endtask

   // One unchecked frame that issues the queued writes one per clock.
   task automatic write_frame();
      wr_t w;
      for (int i = 0; i < DIGITS * PRESCALE; i++) begin
         if (wq.size() > 0) begin
            w       = wq.pop_front();
            wr_en   = 1'b1;
            wr_addr = w.a;
            wr_char = w.c;
            if (int'(w.a) < MSG_LEN) mbuf[w.a] = w.c;
         end else begin
            wr_en = 1'b0;
         end
         @(negedge clk);
      end
      wr_en = 1'b0;
      model_wrap();
   endtask

   initial begin
      logic [5:0] msg [10];
      msg = '{6'd12, 6'd15, 6'd19, 6'd0, 6'd18, 6'd9, 6'd1, 6'd12, 6'd5, 6'd19};
      for (int i = 0; i < MSG_LEN; i++) mbuf[i] = 6'd0;

      #12;
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_segm", 32'(segm), 32'd0);
      chk("rst_tick", 32'(frame_tick), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_frame("walk0", 1'b0, 4'd0, 6'd0);
      run_frame("walk1", 1'b0, 4'd0, 6'd0);

      for (int i = 0; i < 10; i++) wq.push_back('{a: 4'(i), c: msg[i]});
      write_frame();
      run_frame("msg", 1'b0, 4'd0, 6'd0);

      wq.push_back('{a: 4'd13, c: 6'd1});
      wq.push_back('{a: 4'd14, c: 6'd5});
      wq.push_back('{a: 4'd15, c: 6'd18});
      wq.push_back('{a: 4'd10, c: 6'd50});
      wq.push_back('{a: 4'd12, c: 6'd50});
      write_frame();
      run_frame("badwr", 1'b0, 4'd0, 6'd0);

      run_frame("wrA_cur", 1'b1, 4'd0, 6'd1);
      run_frame("wrA_next", 1'b0, 4'd0, 6'd0);

      scroll_en = 1'b1;
      for (int f = 0; f < 2 * MSG_LEN + 1; f++) begin
         run_frame($sformatf("scroll%0d", f), 1'b0, 4'd0, 6'd0);
      end
      scroll_en = 1'b0;
      run_frame("hold0", 1'b0, 4'd0, 6'd0);
      run_frame("hold1", 1'b0, 4'd0, 6'd0);
      scroll_en = 1'b1;
      run_frame("resume0", 1'b0, 4'd0, 6'd0);
      run_frame("resume1", 1'b0, 4'd0, 6'd0);
      scroll_en = 1'b0;
      run_frame("final", 1'b0, 4'd0, 6'd0);

      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_sel_nonzero", 32'(sel != 12'd0), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_sel", 32'(sel), 32'd0);
      chk("midrst_segm", 32'(segm), 32'd0);
      chk("midrst_tick", 32'(frame_tick), 32'd0);
      for (int i = 0; i < MSG_LEN; i++) mbuf[i] = 6'd0;
      off_m = 0;
      frm_m = 0;
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_frame("post_rst", 1'b0, 4'd0, 6'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
